// File: rtl/lif_scan_scheduler_pkg.sv
// Shared types and helpers for the LIF scan scheduler: state encoding,
// default widths and the saturating membrane add.
package lif_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    START = 3'd2,
    DRAIN = 3'd3,
    EVAL  = 3'd4,
    DONE  = 3'd5
  } sched_state_e;

  localparam int DEF_NUM_NEURONS       = 4;
  localparam int DEF_SCORES_PER_NEURON = 4;
  localparam int DEF_SCORE_W           = 4;
  localparam int DEF_VMEM_W            = 16;
  localparam int DEF_LEAK_SHIFT        = 3;

  // Widest membrane the helper supports; callers zero-extend into it.
  localparam int MAX_VMEM_W = 32;

  // a + b clipped to 2^width - 1, computed one bit wider so the carry is kept.
  function automatic logic [MAX_VMEM_W-1:0] sat_add(
    input logic [MAX_VMEM_W-1:0] a,
    input logic [MAX_VMEM_W-1:0] b,
    input int unsigned           width
  );
    logic [MAX_VMEM_W:0] sum;
    logic [MAX_VMEM_W:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = ({{MAX_VMEM_W{1'b0}}, 1'b1} << width) - {{MAX_VMEM_W{1'b0}}, 1'b1};
    if (sum > max_val) begin
      sat_add = max_val[MAX_VMEM_W-1:0];
    end else begin
      sat_add = sum[MAX_VMEM_W-1:0];
    end
  endfunction

endpackage

// File: rtl/lif_scan_scheduler_score_burst_fifo.sv
// Holds one neuron's score burst so it can be replayed to the accumulator
// without the upstream stalls.
module score_burst_fifo
  import lif_sched_pkg::*;
#(
  parameter  int DEPTH = DEF_SCORES_PER_NEURON,
  parameter  int WIDTH = DEF_SCORE_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == LAST_PTR) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // Qualify requests against occupancy and expose status
  always_comb begin
    do_push_s = push && (count_r != FULL_CNT);
    do_pop_s  = pop && (count_r != CNT_W'(0));
    head      = mem_r[rd_ptr_r];
    count     = count_r;
    full      = (count_r == FULL_CNT);
    empty     = (count_r == CNT_W'(0));
  end

  // Pointer and occupancy update; the storage itself needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/lif_scan_scheduler.sv
// Round-robin timestep scan of a LIF neuron array: buffer burst, replay gap-free,
// integrate and fire. Optional membrane leak is enabled by defining LIF_SCAN_LEAK_EN.
module lif_scan_scheduler
  import lif_sched_pkg::*;
#(
  parameter int NUM_NEURONS       = DEF_NUM_NEURONS,
  parameter int SCORES_PER_NEURON = DEF_SCORES_PER_NEURON,
  parameter int SCORE_W           = DEF_SCORE_W,
  parameter int VMEM_W            = DEF_VMEM_W,
  parameter int LEAK_SHIFT        = DEF_LEAK_SHIFT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           step_start,
  output logic                           step_done,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SCORE_W-1:0]             in_score,
  input  logic [VMEM_W-1:0]              threshold,
  output logic                           acc_scan_start_en,
  output logic                           acc_score_valid,
  output logic [SCORE_W-1:0]             acc_score_in,
  input  logic [VMEM_W-1:0]              acc_sum,
  output logic                           spike_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] spike_id
);

  localparam int               IDX_W     = $clog2(NUM_NEURONS);
  localparam int               CNT_W     = $clog2(SCORES_PER_NEURON + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(SCORES_PER_NEURON);

`ifdef LIF_SCAN_LEAK_EN
  localparam bit LEAK_ON = 1'b1;
`else
  localparam bit LEAK_ON = 1'b0;
`endif

  sched_state_e      state_r;
  logic [IDX_W-1:0]  idx_r;
  logic [CNT_W-1:0]  beats_r;
  logic [VMEM_W-1:0] vmem_r [NUM_NEURONS];

  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [CNT_W-1:0]   fifo_count_s;
  logic [SCORE_W-1:0] fifo_head_s;

  logic              accept_s;
  logic              last_fill_s;
  logic [VMEM_W-1:0] vmem_cur_s;
  logic [VMEM_W-1:0] leaked_s;
  logic [VMEM_W-1:0] t_s;
  logic              fire_s;

  score_burst_fifo #(
    .DEPTH (SCORES_PER_NEURON),
    .WIDTH (SCORE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push_s),
    .push_data (in_score),
    .pop       (fifo_pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Upstream handshake, replay pops and the EVAL integrate/compare
  always_comb begin
    accept_s    = (state_r == FILL) && in_valid && in_ready && !fifo_full_s;
    last_fill_s = accept_s && (fifo_count_s == (BURST_LEN - CNT_W'(1)));
    fifo_push_s = accept_s;
    // One pop per replayed beat: the START edge loads beat 0, DRAIN edges load the rest
    if (((state_r == START) || ((state_r == DRAIN) && (beats_r != BURST_LEN))) && !fifo_empty_s) begin
      fifo_pop_s = 1'b1;
    end else begin
      fifo_pop_s = 1'b0;
    end
    vmem_cur_s = vmem_r[idx_r];
    if (LEAK_ON) begin
      leaked_s = vmem_cur_s - (vmem_cur_s >> LEAK_SHIFT);
    end else begin
      leaked_s = vmem_cur_s;
    end
    t_s    = VMEM_W'(sat_add(MAX_VMEM_W'(leaked_s), MAX_VMEM_W'(acc_sum), VMEM_W));
    fire_s = (t_s >= threshold);
  end

  // Scan FSM; every output is loaded on the edge that enters its state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      idx_r             <= '0;
      beats_r           <= '0;
      step_done         <= 1'b0;
      busy              <= 1'b0;
      in_ready          <= 1'b0;
      acc_scan_start_en <= 1'b0;
      acc_score_valid   <= 1'b0;
      acc_score_in      <= '0;
      spike_valid       <= 1'b0;
      spike_id          <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        vmem_r[i] <= '0;
      end
    end else begin
      step_done         <= 1'b0;
      acc_scan_start_en <= 1'b0;
      spike_valid       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (step_start) begin
            state_r  <= FILL;
            idx_r    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FILL: begin
          if (last_fill_s) begin
            state_r           <= START;
            in_ready          <= 1'b0;
            acc_scan_start_en <= 1'b1;
          end
        end
        START: begin
          state_r         <= DRAIN;
          acc_score_valid <= 1'b1;
          acc_score_in    <= fifo_head_s;
          beats_r         <= CNT_W'(1);
        end
        DRAIN: begin
          if (beats_r == BURST_LEN) begin
            state_r         <= EVAL;
            acc_score_valid <= 1'b0;
            acc_score_in    <= '0;
          end else begin
            acc_score_in <= fifo_head_s;
            beats_r      <= beats_r + CNT_W'(1);
          end
        end
        EVAL: begin
          if (fire_s) begin
            spike_valid   <= 1'b1;
            spike_id      <= idx_r;
            vmem_r[idx_r] <= '0;
          end else begin
            vmem_r[idx_r] <= t_s;
          end
          if (idx_r == LAST_IDX) begin
            state_r   <= DONE;
            step_done <= 1'b1;
          end else begin
            idx_r    <= idx_r + IDX_W'(1);
            state_r  <= FILL;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r         <= IDLE;
          busy            <= 1'b0;
          in_ready        <= 1'b0;
          acc_score_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_scan_scheduler.sv
// Scoreboard bench for lif_scan_scheduler with a behavioural accumulator that
// clears on start or on any invalid cycle.
module tb_lif_scan_scheduler;

  localparam int NN  = 4;
  localparam int SPN = 4;
  localparam int SW  = 4;
  localparam int VW  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          step_start;
  logic          step_done;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_score;
  logic [VW-1:0] threshold;
  logic          acc_scan_start_en;
  logic          acc_score_valid;
  logic [SW-1:0] acc_score_in;
  logic [VW-1:0] acc_sum;
  logic          spike_valid;
  logic [1:0]    spike_id;

  always #5 clk = ~clk;

  lif_scan_scheduler #(
    .NUM_NEURONS       (NN),
    .SCORES_PER_NEURON (SPN),
    .SCORE_W           (SW),
    .VMEM_W            (VW),
    .LEAK_SHIFT        (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .step_start        (step_start),
    .step_done         (step_done),
    .busy              (busy),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_score          (in_score),
    .threshold         (threshold),
    .acc_scan_start_en (acc_scan_start_en),
    .acc_score_valid   (acc_score_valid),
    .acc_score_in      (acc_score_in),
    .acc_sum           (acc_sum),
    .spike_valid       (spike_valid),
    .spike_id          (spike_id)
  );

  int compared   = 0;
  int mismatched = 0;
  int beat_q[$];
  int sum_q[$];
  int spike_q[$];
  int tb_vmem[NN];
  int thr = 20;

  logic [VW-1:0] model_sum    = '0;
  logic          prev_valid_q = 1'b0;
  logic          eval_q       = 1'b0;
  logic          eval_now;
  int            eval_cnt     = 0;
  logic          ovr_en       = 1'b0;
  int            ovr_idx      = 0;
  int            ovr_val      = 0;
  int            run_len      = 0;
  int            done_cnt     = 0;
  logic          abort_pending = 1'b0;

  // Accumulator model; an override can replace one neuron's sum in its EVAL cycle
  assign eval_now = prev_valid_q && !acc_score_valid;
  assign acc_sum  = (ovr_en && eval_now && (eval_cnt == ovr_idx)) ? VW'(ovr_val) : model_sum;

  always @(posedge clk) begin
    if (acc_scan_start_en || !acc_score_valid) model_sum <= '0;
    else model_sum <= model_sum + VW'(acc_score_in);
    prev_valid_q <= acc_score_valid;
    eval_q       <= eval_now;
    if (step_start) eval_cnt <= 0;
    else if (eval_now) eval_cnt <= eval_cnt + 1;
  end

  // Output monitor: beats, burst length, EVAL sum, spikes, step_done timing
  always @(negedge clk) begin
    int e;
    if (acc_scan_start_en === 1'b1) begin
      compared++;
      if (acc_score_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL start_valid_overlap: acc_score_valid=%b required 0", acc_score_valid);
      end
    end
    if (acc_score_valid === 1'b1) begin
      run_len++;
      compared++;
      if (beat_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_beat: acc_score_in=%0d with no beat queued", acc_score_in);
      end else begin
        e = beat_q.pop_front();
        if (acc_score_in !== SW'(e)) begin
          mismatched++;
          $display("FAIL beat_data: acc_score_in=%0d required %0d", acc_score_in, e);
        end
      end
    end else if (run_len != 0) begin
      if (!abort_pending) begin
        compared++;
        if (run_len != SPN) begin
          mismatched++;
          $display("FAIL burst_len: valid run=%0d required %0d", run_len, SPN);
        end
        compared++;
        if (sum_q.size() == 0) begin
          mismatched++;
          $display("FAIL eval_sum: sum=%0d with no sum queued", model_sum);
        end else begin
          e = sum_q.pop_front();
          if (model_sum !== VW'(e)) begin
            mismatched++;
            $display("FAIL eval_sum: sum=%0d required %0d", model_sum, e);
          end
        end
      end
      run_len = 0;
    end
    if (spike_valid === 1'b1) begin
      compared++;
      if (spike_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_spike: spike_id=%0d with no spike expected", spike_id);
      end else begin
        e = spike_q.pop_front();
        if (spike_id !== 2'(e)) begin
          mismatched++;
          $display("FAIL spike_id: spike_id=%0d required %0d", spike_id, e);
        end
      end
    end
    if (step_done === 1'b1) begin
      done_cnt++;
      compared++;
      if (eval_q !== 1'b1) begin
        mismatched++;
        $display("FAIL done_timing: step_done not 1 cycle after EVAL (eval_q=%b)", eval_q);
      end
    end
  end

  task automatic feed_neuron(input int sc[SPN], input bit gappy, input bit poke);
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int k      = 0;
    int cyc    = 0;
    int pat_i  = 0;
    bit poked  = 1'b0;
    while ((k < SPN) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
      in_valid = (gappy && (pat_i < 7)) ? pat[pat_i] : 1'b1;
      in_score = SW'(sc[k]);
      if (in_ready) pat_i++;
      if (poke && !poked && acc_score_valid) begin
        step_start = 1'b1;
        poked      = 1'b1;
      end else begin
        step_start = 1'b0;
      end
      if (in_valid && in_ready) begin
        beat_q.push_back(sc[k]);
        k++;
      end
    end
    compared++;
    if (k != SPN) begin
      mismatched++;
      $display("FAIL feed_timeout: accepted %0d beats required %0d", k, SPN);
    end
  endtask

  task automatic do_step(input int sc[NN][SPN], input int gappy_n, input int poke_n,
                         input int ovr_n, input int ovr_v);
    int row[SPN];
    int d0;
    int s;
    int t;
    for (int n = 0; n < NN; n++) begin
      s = 0;
      for (int j = 0; j < SPN; j++) s += sc[n][j];
      sum_q.push_back(s);
      t = tb_vmem[n] + ((n == ovr_n) ? ovr_v : s);
      if (t > 65535) t = 65535;
      if (t >= thr) begin
        spike_q.push_back(n);
        tb_vmem[n] = 0;
      end else begin
        tb_vmem[n] = t;
      end
    end
    ovr_en  = (ovr_n >= 0);
    ovr_idx = ovr_n;
    ovr_val = ovr_v;
    d0 = done_cnt;
    @(negedge clk);
    threshold  = VW'(thr);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    for (int n = 0; n < NN; n++) begin
      for (int j = 0; j < SPN; j++) row[j] = sc[n][j];
      feed_neuron(row, n == gappy_n, n == poke_n);
    end
    @(negedge clk);
    in_valid   = 1'b0;
    step_start = 1'b0;
    for (int c = 0; (c < 200) && (done_cnt == d0); c++) @(negedge clk);
    repeat (4) @(negedge clk);
    ovr_en = 1'b0;
    compared++;
    if (done_cnt != d0 + 1) begin
      mismatched++;
      $display("FAIL step_done_count: got %0d pulses required 1", done_cnt - d0);
    end
    compared++;
    if (spike_q.size() != 0 || beat_q.size() != 0 || sum_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover: spikes=%0d beats=%0d sums=%0d required 0/0/0",
               spike_q.size(), beat_q.size(), sum_q.size());
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_after_step: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    logic [15:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {step_done, busy, in_ready, acc_scan_start_en, acc_score_valid,
            acc_score_in, spike_valid, spike_id, 4'b0000};
    compared++;
    if (outs !== 16'h0000) begin
      mismatched++;
      $display("FAIL reset_outputs: outputs=%h required 0000", outs);
    end
    rst = 1'b0;
    for (int n = 0; n < NN; n++) tb_vmem[n] = 0;
    @(negedge clk);
  endtask

  task automatic test_spike_basic();
    int sc[NN][SPN] = '{'{5, 5, 5, 5}, '{1, 2, 3, 4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    thr = 20;
    do_step(sc, -1, -1, -1, 0);
    do_step(sc, -1, -1, -1, 0);
  endtask

  task automatic test_gappy_fill();
    int sc[NN][SPN] = '{'{3, 3, 3, 3}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    thr = 20;
    do_step(sc, 0, -1, -1, 0);
  endtask

  task automatic test_saturation();
    int za[NN][SPN] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    int sb[NN][SPN] = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{15, 15, 15, 15}, '{0, 0, 0, 0}};
    thr = 65535;
    do_step(za, -1, -1, 2, 65530);
    do_step(sb, -1, -1, -1, 0);
  endtask

  task automatic test_reset_mid_drain();
    int row[SPN] = '{5, 5, 5, 5};
    int sc[NN][SPN] = '{'{3, 3, 3, 3}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{5, 5, 5, 5}};
    int seen = 0;
    int d0;
    logic [15:0] outs;
    thr = 20;
    d0 = done_cnt;
    @(negedge clk);
    threshold  = VW'(thr);
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
    feed_neuron(row, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; (c < 50) && (seen < 2); c++) begin
      @(negedge clk);
      if (acc_score_valid) seen++;
    end
    compared++;
    if (seen != 2) begin
      mismatched++;
      $display("FAIL drain_reach: saw %0d beats required 2", seen);
    end
    abort_pending = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    outs = {step_done, busy, in_ready, acc_scan_start_en, acc_score_valid,
            acc_score_in, spike_valid, spike_id, 4'b0000};
    compared++;
    if (outs !== 16'h0000) begin
      mismatched++;
      $display("FAIL mid_drain_reset: outputs=%h required 0000", outs);
    end
    rst = 1'b0;
    beat_q.delete();
    for (int n = 0; n < NN; n++) tb_vmem[n] = 0;
    repeat (3) @(negedge clk);
    abort_pending = 1'b0;
    compared++;
    if (done_cnt != d0) begin
      mismatched++;
      $display("FAIL abort_done: step_done pulses=%0d required 0", done_cnt - d0);
    end
    do_step(sc, -1, -1, -1, 0);
  endtask

  task automatic test_start_during_drain();
    int sc[NN][SPN] = '{'{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}};
    thr = 20;
    do_step(sc, -1, 2, -1, 0);
    do_step(sc, -1, 1, -1, 0);
  endtask

  initial begin
    rst        = 1'b1;
    step_start = 1'b0;
    in_valid   = 1'b0;
    in_score   = '0;
    threshold  = VW'(20);
    test_reset();
    test_spike_basic();
    test_gappy_fill();
    test_saturation();
    test_reset_mid_drain();
    test_start_during_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
